// File: rtl/filter_nsec.sv
`timescale 1ns/1ps
// filter_nsec: cascade of NSECTIONS two-pole resonators, computed serially
// with one shared multiplier/accumulator (one multiply per cycle).
// Double-buffered coefficients: words are written into a shadow bank and
// swapped into the active bank on the first accepted start after a full load.
// Optional feature macro: FILTER_SAT_EN (saturate section results instead of wrapping).
// Ports:
//   clk        clock, all state on rising edge
//   rst_an     synchronous active-low reset
//   coef_in    coefficient word (c1[0], c2[0], c1[1], c2[1], ...)
//   coef_load  write coef_in into the shadow bank this cycle
//   sig_in     input sample, latched on an accepted start
//   start      request one sample computation (accepted only when idle)
//   sig_out    output sample, held until the next done
//   done       one-cycle pulse, sig_out/ovf updated
//   busy       high from the accepted start through the done cycle
//   ovf        with done: some section result left the DW range
module filter_nsec #(
    parameter int NSECTIONS = 6,
    parameter int DW        = 16,
    parameter int CW        = 10,
    parameter int CSHIFT    = 8
) (
    input  logic                 clk,
    input  logic                 rst_an,
    input  logic signed [CW-1:0] coef_in,
    input  logic                 coef_load,
    input  logic signed [DW-1:0] sig_in,
    input  logic                 start,
    output logic signed [DW-1:0] sig_out,
    output logic                 done,
    output logic                 busy,
    output logic                 ovf
);

    localparam int AW = DW + CW + 1;
    localparam int PW = DW + CW;
    localparam int SW = (NSECTIONS > 1) ? $clog2(NSECTIONS) : 1;
    localparam int IW = SW + 1;
    localparam int NW = 2 * NSECTIONS;

    localparam logic [SW-1:0] LAST_SEC = SW'(NSECTIONS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MA,
        S_MB,
        S_DONE
    } state_t;

    state_t state;

    logic signed [CW-1:0] shadow     [NW];
    logic signed [CW-1:0] shadow_nxt [NW];
    logic signed [CW-1:0] active     [NW];
    logic [IW-1:0]        idx;
    logic                 pending;

    logic signed [DW-1:0] y1 [NSECTIONS];
    logic signed [DW-1:0] y2 [NSECTIONS];

    logic [SW-1:0]        sec;
    logic signed [DW-1:0] x;
    logic signed [AW-1:0] acc;
    logic                 ovf_acc;

    logic                 accept;
    logic signed [CW-1:0] mc;
    logic signed [DW-1:0] my;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] acc_shr;
    logic signed [AW-1:0] x_ext;
    logic signed [AW-1:0] t;
    logic                 t_ovf;
    logic signed [DW-1:0] y;

    assign accept = (state == S_IDLE) && start;

    // Busy covers the accepting cycle itself, so it is high whenever the
    // FSM is running or a start is being taken right now.
    assign busy = (state != S_IDLE) || (start && rst_an);

    // Shadow bank as it will look after this cycle's write; a swap in the
    // same cycle picks up that write.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            shadow_nxt[i] = shadow[i];
        end
        if (coef_load) begin
            shadow_nxt[idx] = coef_in;
        end
    end

    // Operand select: MA uses c1/y1, MB uses c2/y2 of the current section.
    always_comb begin
        mc = active[{sec, 1'b0}];
        my = y1[sec];
        if (state == S_MB) begin
            mc = active[{sec, 1'b1}];
            my = y2[sec];
        end
    end

    assign prod     = mc * my;
    assign prod_ext = {prod[PW-1], prod};
    assign acc_sum  = acc + prod_ext;
    assign acc_shr  = acc_sum >>> CSHIFT;
    assign x_ext    = {{(CW + 1){x[DW-1]}}, x};
    assign t        = x_ext + acc_shr;

    // In range only if all bits from the DW sign bit upward agree.
    assign t_ovf = !((&t[AW-1:DW-1]) || !(|t[AW-1:DW-1]));

`ifdef FILTER_SAT_EN
    always_comb begin
        y = t[DW-1:0];
        if (t_ovf) begin
            y = t[AW-1] ? {1'b1, {(DW - 1){1'b0}}}
                        : {1'b0, {(DW - 1){1'b1}}};
        end
    end
`else
    assign y = t[DW-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_an) begin
            state   <= S_IDLE;
            sig_out <= '0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            idx     <= '0;
            pending <= 1'b0;
            sec     <= '0;
            x       <= '0;
            acc     <= '0;
            ovf_acc <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
            for (int k = 0; k < NSECTIONS; k++) begin
                y1[k] <= '0;
                y2[k] <= '0;
            end
        end else begin
            done <= 1'b0;

            if (coef_load) begin
                shadow[idx] <= coef_in;
                if (idx == LAST_IDX) begin
                    idx     <= '0;
                    pending <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end

            // Only a completed bank is ever marked pending.
            if (accept && pending) begin
                for (int i = 0; i < NW; i++) begin
                    active[i] <= shadow_nxt[i];
                end
                pending <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        x       <= sig_in;
                        sec     <= '0;
                        ovf_acc <= 1'b0;
                        state   <= S_MA;
                    end
                end
                S_MA: begin
                    acc   <= prod_ext;
                    state <= S_MB;
                end
                S_MB: begin
                    y2[sec] <= y1[sec];
                    y1[sec] <= y;
                    x       <= y;
                    ovf_acc <= ovf_acc | t_ovf;
                    if (sec == LAST_SEC) begin
                        sig_out <= y;
                        ovf     <= ovf_acc | t_ovf;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        sec   <= sec + 1'b1;
                        state <= S_MA;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_nsec.sv
`timescale 1ns/1ps
// tb_filter_nsec: directed checks of filter_nsec with hand-computed results
// (NSECTIONS=6, DW=16, CW=10, CSHIFT=8).
module tb_filter_nsec;

    logic               clk = 1'b0;
    logic               rst_an = 1'b0;
    logic signed [9:0]  coef_in = '0;
    logic               coef_load = 1'b0;
    logic signed [15:0] sig_in = '0;
    logic               start = 1'b0;
    logic signed [15:0] sig_out;
    logic               done;
    logic               busy;
    logic               ovf;

    int tests = 0;
    int fails = 0;

    filter_nsec #(
        .NSECTIONS(6),
        .DW(16),
        .CW(10),
        .CSHIFT(8)
    ) dut (
        .clk(clk),
        .rst_an(rst_an),
        .coef_in(coef_in),
        .coef_load(coef_load),
        .sig_in(sig_in),
        .start(start),
        .sig_out(sig_out),
        .done(done),
        .busy(busy),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_an    = 1'b0;
        start     = 1'b0;
        coef_load = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_an = 1'b1;
    endtask

    // Full 12-word load: c1[0] = c0, all other coefficients zero.
    task automatic load_c10(input logic signed [9:0] c0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            coef_load = 1'b1;
            coef_in   = (i == 0) ? c0 : 10'sd0;
        end
        @(negedge clk);
        coef_load = 1'b0;
    endtask

    // One sample: returns result, ovf, start-to-done cycles and busy cycles.
    task automatic run(input  logic signed [15:0] xin,
                       output logic signed [15:0] yout,
                       output logic               oout,
                       output int                 lat,
                       output int                 bcnt);
        bit got;
        @(negedge clk);
        sig_in = xin;
        start  = 1'b1;
        #1;
        lat  = 0;
        bcnt = 0;
        got  = 1'b0;
        yout = 'x;
        oout = 1'bx;
        while (!got && lat < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            if (done) begin
                got  = 1'b1;
                yout = sig_out;
                oout = ovf;
            end
        end
        if (got && busy) bcnt++;
        @(posedge clk);
        #1;
    endtask

    logic signed [15:0] yv;
    logic               ov;
    int                 lat;
    int                 bc;
    logic signed [15:0] dv [8];
    int                 dc [8];
    int                 nd;

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_sig_out", sig_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);

        // 1: zero coefficients pass the sample through
        run(16'sd16, yv, ov, lat, bc);
        check("t1_latency", lat, 13);
        check("t1_sig_out", yv, 16);
        check("t1_ovf", ov, 0);
        check("t1_busy_cycles", bc, 14);

        // 2: c1[0] = 0.5, constant input converges toward 2000
        do_reset();
        load_c10(10'sd128);
        run(16'sd1000, yv, ov, lat, bc);
        check("t2_s1", yv, 1000);
        run(16'sd1000, yv, ov, lat, bc);
        check("t2_s2", yv, 1500);
        run(16'sd1000, yv, ov, lat, bc);
        check("t2_s3", yv, 1750);
        run(16'sd1000, yv, ov, lat, bc);
        check("t2_s4", yv, 1875);
        run(16'sd1000, yv, ov, lat, bc);
        check("t2_s5_floor", yv, 1937);

        // 3: c1[0] = 1.0, second sample overflows
        do_reset();
        load_c10(10'sd256);
        run(16'sd20000, yv, ov, lat, bc);
        check("t3_s1", yv, 20000);
        check("t3_s1_ovf", ov, 0);
        run(16'sd20000, yv, ov, lat, bc);
`ifdef FILTER_SAT_EN
        check("t3_s2_sat", yv, 32767);
`else
        check("t3_s2_wrap", yv, -25536);
`endif
        check("t3_s2_ovf", ov, 1);

        // 4: full load during run A completes after start B; C uses the
        //    new bank; partial load before D is never applied
        do_reset();
        nd = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            start     = (c == 0) || (c == 14) || (c == 28) || (c == 42);
            sig_in    = (c == 0)  ? 16'sd100 :
                        (c == 14) ? 16'sd200 :
                        (c == 28) ? 16'sd300 : 16'sd10;
            coef_load = (c >= 6 && c < 18) || (c >= 30 && c < 35);
            coef_in   = (c == 6) ? 10'sd256 : 10'sd0;
            @(posedge clk);
            #1;
            if (done && nd < 8) begin
                dv[nd] = sig_out;
                dc[nd] = c;
                nd++;
            end
        end
        start     = 1'b0;
        coef_load = 1'b0;
        check("t4_done_count", nd, 4);
        check("t4_A_old_bank", dv[0], 100);
        check("t4_B_old_bank", dv[1], 200);
        check("t4_C_new_bank", dv[2], 500);
        check("t4_D_no_partial", dv[3], 510);

        // 5: start held high, one done every 14 cycles
        do_reset();
        nd = 0;
        @(negedge clk);
        sig_in = 16'sd7;
        start  = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (done && nd < 8) begin
                dc[nd] = c;
                dv[nd] = sig_out;
                nd++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("t5_done_count", nd, 4);
        check("t5_first_done", dc[0], 12);
        check("t5_period_1", dc[1] - dc[0], 14);
        check("t5_period_2", dc[2] - dc[1], 14);
        check("t5_value", dv[3], 7);

        // 6: reset during MB(3) aborts the run
        do_reset();
        run(16'sd555, yv, ov, lat, bc);
        check("t6_pre", yv, 555);
        @(negedge clk);
        sig_in = 16'sd777;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_an = 1'b0;
        @(posedge clk);
        #1;
        rst_an = 1'b1;
        check("t6_done", done, 0);
        check("t6_busy", busy, 0);
        check("t6_sig_out", sig_out, 0);
        run(16'sd42, yv, ov, lat, bc);
        check("t6_after", yv, 42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
